// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one single-ported,
// variable-latency memory; data wins ties unless it won the previous grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_done,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_done,
    output logic          stall_f,
    output logic          stall_m,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   elig_i;
    logic   elig_d;
    logic   grant_i;
    logic   grant_d;
    logic   retire_i;
    logic   retire_d;

    // Freeze each pipeline port until its own access retires.
    assign stall_f = inst_req & ~inst_done;
    assign stall_m = data_req & ~data_done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_i) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant/retire decode; a port whose done is pulsing is masked so it is not re-granted.
    always_comb begin
        elig_i   = inst_req & ~inst_done;
        elig_d   = data_req & ~data_done;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        retire_i = 1'b0;
        retire_d = 1'b0;
        case (state)
            IDLE: begin
                grant_d = elig_d & (~elig_i | (last_grant == GNT_I));
                grant_i = elig_i & ~grant_d;
            end
            BUSY_I:  retire_i = mem_ready;
            BUSY_D:  retire_d = mem_ready;
            default: ;
        endcase
    end

    // Memory-side request registers, completion pulses and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_I;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            inst_done <= retire_i;
            data_done <= retire_d;
            if (grant_d || grant_i) begin
                mem_req    <= 1'b1;
                last_grant <= grant_d ? GNT_D : GNT_I;
                mem_we     <= grant_d & data_we;
                mem_addr   <= grant_d ? data_addr : inst_addr;
                mem_wdata  <= grant_d ? data_wdata : '0;
            end else if (retire_i || retire_d) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (retire_i) begin
                inst_rdata <= mem_rdata;
            end
            // Stores leave the previous load result in place.
            if (retire_d && !mem_we) begin
                data_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level reference model checked
// every cycle, plus hand-computed cycle/value expectations for each scenario.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        stall_f;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_req  (inst_req),
        .inst_addr (inst_addr),
        .inst_rdata(inst_rdata),
        .inst_done (inst_done),
        .data_req  (data_req),
        .data_we   (data_we),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .data_done (data_done),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: answers after cfg_wait not-ready cycles of a request.
    int          cfg_wait  = 0;
    logic [31:0] cfg_rdata = '0;
    int          wait_left = 0;

    always begin
        @(posedge clk);
        #1;
        if (mem_req) begin
            if (wait_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = cfg_rdata;
            end else begin
                wait_left--;
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_0BAD;
            end
        end else begin
            mem_ready = 1'b0;
            wait_left = cfg_wait;
            mem_rdata = 32'hBAD0_0BAD;
        end
    end

    // Reference model: who owns the memory, what was latched, what each port last got.
    int          m_owner  = 0;   // 0 none, 1 fetch, 2 data
    bit          m_last_d = 1'b0;
    logic [31:0] m_addr   = '0;
    logic        m_we     = 1'b0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_ird    = '0;
    logic [31:0] m_drd    = '0;
    logic        m_idone  = 1'b0;
    logic        m_ddone  = 1'b0;

    task model_reset();
        m_owner  = 0;
        m_last_d = 1'b0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_wdata  = '0;
        m_ird    = '0;
        m_drd    = '0;
        m_idone  = 1'b0;
        m_ddone  = 1'b0;
    endtask

    task model_step();
        bit want_i;
        bit want_d;
        want_i  = inst_req && !m_idone;
        want_d  = data_req && !m_ddone;
        m_idone = 1'b0;
        m_ddone = 1'b0;
        if (m_owner == 0) begin
            if (want_d && (!want_i || !m_last_d)) begin
                m_owner = 2; m_last_d = 1'b1;
                m_addr = data_addr; m_we = data_we; m_wdata = data_wdata;
            end else if (want_i) begin
                m_owner = 1; m_last_d = 1'b0;
                m_addr = inst_addr; m_we = 1'b0; m_wdata = '0;
            end
        end else if (mem_ready) begin
            if (m_owner == 1) begin
                m_ird = mem_rdata; m_idone = 1'b1;
            end else begin
                if (!m_we) m_drd = mem_rdata;
                m_ddone = 1'b1;
            end
            m_owner = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        check("mem_req", mem_req, m_owner != 0);
        if (m_owner != 0) begin
            check("mem_we", mem_we, m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        check("inst_done", inst_done, m_idone);
        check("data_done", data_done, m_ddone);
        check("inst_rdata", inst_rdata, m_ird);
        check("data_rdata", data_rdata, m_drd);
        check("stall_f", stall_f, inst_req && !m_idone);
        check("stall_m", stall_m, data_req && !m_ddone);
        if (!rst) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          stable;
        logic [31:0] gr [$];
        int          dd [$];
        int          id [$];
        logic        prev_req;

        // Reset values
        repeat (2) tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_inst_done", inst_done, 0);
        check("rst_data_rdata", data_rdata, 0);
        rst = 1'b0;

        // Zero-wait fetch
        cfg_wait = 0; cfg_rdata = 32'h2008_0005;
        tick();
        inst_req = 1'b1; inst_addr = 32'h0000_0040;
        #1;
        check("t1_c0_stall_f", stall_f, 1);
        check("t1_c0_mem_req", mem_req, 0);
        tick();
        check("t1_c1_mem_req", mem_req, 1);
        check("t1_c1_mem_addr", mem_addr, 32'h0000_0040);
        check("t1_c1_stall_f", stall_f, 1);
        tick();
        check("t1_c2_inst_done", inst_done, 1);
        check("t1_c2_inst_rdata", inst_rdata, 32'h2008_0005);
        check("t1_c2_stall_f", stall_f, 0);
        inst_req = 1'b0;
        tick();
        check("t1_c3_inst_done", inst_done, 0);

        // Load with three wait cycles
        cfg_wait = 3; cfg_rdata = 32'h1234_5678;
        tick();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100;
        n = 0; stable = 0;
        while (!data_done && n < 40) begin
            tick(); n++;
            if (mem_req && mem_addr == 32'h0000_0100) stable++;
        end
        check("t2_done_latency", n, 5);
        check("t2_addr_stable", stable, 4);
        check("t2_data_rdata", data_rdata, 32'h1234_5678);
        data_req = 1'b0;

        // Store leaves data_rdata alone
        cfg_wait = 1; cfg_rdata = 32'hFFFF_0000;
        tick();
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0104; data_wdata = 32'hDEAD_BEEF;
        n = 0;
        while (!data_done && n < 40) begin
            tick(); n++;
            if (mem_req) begin
                check("t3_mem_we", mem_we, 1);
                check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
        end
        check("t3_done_latency", n, 3);
        check("t3_data_rdata_held", data_rdata, 32'h1234_5678);
        data_req = 1'b0; data_we = 1'b0;

        // Asynchronous reset while a load waits, then a fresh fetch
        cfg_wait = 50;
        tick();
        data_req = 1'b1; data_addr = 32'h0000_0500;
        repeat (3) tick();
        check("t6_busy_mem_req", mem_req, 1);
        #2;
        cfg_wait = 2; cfg_rdata = 32'hCAFE_F00D;
        rst = 1'b1;
        #1;
        check("t6_rst_mem_req", mem_req, 0);
        check("t6_rst_mem_we", mem_we, 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        check("t6_rst_mem_wdata", mem_wdata, 0);
        check("t6_rst_inst_rdata", inst_rdata, 0);
        check("t6_rst_data_rdata", data_rdata, 0);
        check("t6_rst_dones", {inst_done, data_done}, 0);
        data_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        inst_req = 1'b1; inst_addr = 32'h0000_0080;
        n = 0;
        while (!inst_done && n < 40) begin
            tick(); n++;
        end
        check("t6_fetch_latency", n, 4);
        check("t6_fetch_rdata", inst_rdata, 32'hCAFE_F00D);
        inst_req = 1'b0;

        // Both ports held: alternating grants starting with data
        cfg_wait = 0; cfg_rdata = 32'h5555_AAAA;
        tick();
        inst_req = 1'b1; inst_addr = 32'h0000_0200;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0300;
        prev_req = mem_req;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (mem_req && !prev_req) gr.push_back(mem_addr);
            if (data_done) dd.push_back(c);
            if (inst_done) id.push_back(c);
            if (c == 8) inst_req = 1'b0;
            if (c == 10) data_req = 1'b0;
            prev_req = mem_req;
        end
        check("t4_n_grants", gr.size(), 5);
        check("t4_n_ddone", dd.size(), 3);
        check("t4_n_idone", id.size(), 2);
        if (gr.size() == 5) begin
            check("t4_grant0_D", gr[0], 32'h0000_0300);
            check("t4_grant1_I", gr[1], 32'h0000_0200);
            check("t4_grant2_D", gr[2], 32'h0000_0300);
            check("t4_grant3_I", gr[3], 32'h0000_0200);
            check("t4_grant4_D", gr[4], 32'h0000_0300);
        end
        if (dd.size() == 3 && id.size() == 2) begin
            check("t4_ddone0_cycle", dd[0], 2);
            check("t4_idone0_cycle", id[0], 4);
            check("t4_ddone1_cycle", dd[1], 6);
            check("t4_idone1_cycle", id[1], 8);
            check("t4_ddone2_cycle", dd[2], 10);
        end

        // Request held through its done: no re-grant in the done cycle
        tick();
        inst_req = 1'b1; inst_addr = 32'h0000_0240;
        tick();
        check("t5_c1_mem_req", mem_req, 1);
        tick();
        check("t5_c2_inst_done", inst_done, 1);
        check("t5_c2_mem_req", mem_req, 0);
        tick();
        check("t5_c3_mem_req", mem_req, 0);
        check("t5_c3_inst_done", inst_done, 0);
        tick();
        check("t5_c4_mem_req", mem_req, 1);
        tick();
        check("t5_c5_inst_done", inst_done, 1);
        inst_req = 1'b0;
        tick();
        check("t5_c6_mem_req", mem_req, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
